// File: rtl/dds_pkg.sv
// Shared DDS definitions: loader FSM states, table sizing helper and default widths
// that the loader and the DDS core both use.
package dds_pkg;

  localparam int DDS_SAMPLE_BITS       = 16;
  localparam int DDS_TABLE_LENGTH_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } dds_table_loader_state_t;

  function automatic int table_length(input int bits);
    return 1 << bits;
  endfunction

endpackage

// File: rtl/dds_table_ram.sv
// One waveform table bank: a single write port and two independent registered read
// ports. The array itself is never reset; a read of the address being written returns the old data.
module dds_table_ram #(
  parameter int SAMPLE_BITS = 16,
  parameter int ADDR_BITS   = 8
) (
  input  logic                             clock,
  input  logic                             aresetn,
  input  logic                             i_we,
  input  logic [ADDR_BITS-1:0]             i_waddr,
  input  logic [SAMPLE_BITS-1:0]           i_wdata,
  input  logic [1:0]                       i_re,
  input  logic [1:0][ADDR_BITS-1:0]        i_raddr,
  output logic [1:0][SAMPLE_BITS-1:0]      o_rdata
);

  logic [SAMPLE_BITS-1:0]      r_mem [0:(2**ADDR_BITS)-1];
  logic [1:0][SAMPLE_BITS-1:0] r_rdata;

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clock) begin
    if (!aresetn) begin
      r_rdata <= '0;
    end else begin
      for (int p = 0; p < 2; p++)
        if (i_re[p]) r_rdata[p] <= r_mem[i_raddr[p]];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dds_table_loader.sv
// DDS waveform table writer: loads a full table from an AXI4-Stream packet and serves
// two read ports. DDS_TABLE_LOADER_DOUBLE_BUFFER_EN selects the double-buffered build.
module dds_table_loader
  import dds_pkg::*;
#(
  parameter int SAMPLE_BITS       = DDS_SAMPLE_BITS,
  parameter int TABLE_LENGTH_BITS = DDS_TABLE_LENGTH_BITS
) (
  input  logic                                clock,
  input  logic                                aresetn,
  input  logic                                saxis_table_tvalid,
  output logic                                saxis_table_tready,
  input  logic [SAMPLE_BITS-1:0]              saxis_table_tdata,
  input  logic                                saxis_table_tlast,
  input  logic [1:0][TABLE_LENGTH_BITS-1:0]   table_addr,
  input  logic [1:0]                          table_read_en,
  output logic [1:0][SAMPLE_BITS-1:0]         table_data,
  output logic                                active_bank,
  output logic                                load_done,
  output logic                                load_error
);

  localparam int                          TABLE_LENGTH = table_length(TABLE_LENGTH_BITS);
  localparam logic [TABLE_LENGTH_BITS-1:0] LAST_IDX    = TABLE_LENGTH_BITS'(TABLE_LENGTH - 1);

  dds_table_loader_state_t      r_state;
  logic [TABLE_LENGTH_BITS-1:0] r_wptr;
  logic                         r_done;
  logic                         r_err;
  logic                         r_active;

  logic w_beat;
  logic w_we;
  logic w_at_end;

  assign saxis_table_tready = aresetn;
  assign w_beat   = saxis_table_tvalid & aresetn;
  assign w_we     = w_beat & (r_state != ST_DRAIN);
  assign w_at_end = (r_wptr == LAST_IDX);

  // IDLE always sits at wptr 0, so IDLE and LOAD share one decision tree on wptr/tlast.
  always_ff @(posedge clock) begin
    if (!aresetn) begin
      r_state  <= ST_IDLE;
      r_wptr   <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_beat) begin
        case (r_state)
          ST_IDLE, ST_LOAD: begin
            if (saxis_table_tlast) begin
              r_state <= ST_IDLE;
              r_wptr  <= '0;
              if (w_at_end) begin
                r_done <= 1'b1;
`ifdef DDS_TABLE_LOADER_DOUBLE_BUFFER_EN
                r_active <= ~r_active;
`endif
              end else begin
                r_err <= 1'b1;
              end
            end else if (w_at_end) begin
              r_state <= ST_DRAIN;
              r_wptr  <= '0;
            end else begin
              r_state <= ST_LOAD;
              r_wptr  <= r_wptr + 1'b1;
            end
          end
          ST_DRAIN: begin
            if (saxis_table_tlast) begin
              r_state <= ST_IDLE;
              r_err   <= 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_wptr  <= '0;
          end
        endcase
      end
    end
  end

  assign load_done  = r_done;
  assign load_error = r_err;

`ifdef DDS_TABLE_LOADER_DOUBLE_BUFFER_EN
  logic [1:0][1:0][SAMPLE_BITS-1:0] w_rdata;
  logic [1:0]                       r_rd_sel;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    dds_table_ram #(
      .SAMPLE_BITS (SAMPLE_BITS),
      .ADDR_BITS   (TABLE_LENGTH_BITS)
    ) u_ram (
      .clock   (clock),
      .aresetn (aresetn),
      .i_we    (w_we & (r_active != 1'(b))),
      .i_waddr (r_wptr),
      .i_wdata (saxis_table_tdata),
      .i_re    (table_read_en),
      .i_raddr (table_addr),
      .o_rdata (w_rdata[b])
    );
  end

  // Remember which bank each port sampled so a commit can't alter an in-flight read.
  always_ff @(posedge clock) begin
    if (!aresetn) begin
      r_rd_sel <= '0;
    end else begin
      for (int p = 0; p < 2; p++)
        if (table_read_en[p]) r_rd_sel[p] <= r_active;
    end
  end

  always_comb begin
    table_data = '0;
    for (int p = 0; p < 2; p++)
      table_data[p] = w_rdata[r_rd_sel[p]][p];
  end

  assign active_bank = r_active;
`else
  dds_table_ram #(
    .SAMPLE_BITS (SAMPLE_BITS),
    .ADDR_BITS   (TABLE_LENGTH_BITS)
  ) u_ram (
    .clock   (clock),
    .aresetn (aresetn),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (saxis_table_tdata),
    .i_re    (table_read_en),
    .i_raddr (table_addr),
    .o_rdata (table_data)
  );

  assign active_bank = r_active;
`endif

endmodule

// File: tb/tb_dds_table_loader.sv
// Directed bench for dds_table_loader with a packet-level reference model checked every cycle.
module tb_dds_table_loader;
  import dds_pkg::*;

`ifdef DDS_TABLE_LOADER_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             aresetn = 1'b0;
  logic             tvalid = 1'b0;
  logic             tready;
  logic [15:0]      tdata = '0;
  logic             tlast = 1'b0;
  logic [1:0][7:0]  addr = '0;
  logic [1:0]       re = '0;
  logic [1:0][15:0] tdat;
  logic             abank, ldone, lerr;

  dds_table_loader #(.SAMPLE_BITS(16), .TABLE_LENGTH_BITS(8)) dut (
    .clock              (clock),
    .aresetn            (aresetn),
    .saxis_table_tvalid (tvalid),
    .saxis_table_tready (tready),
    .saxis_table_tdata  (tdata),
    .saxis_table_tlast  (tlast),
    .table_addr         (addr),
    .table_read_en      (re),
    .table_data         (tdat),
    .active_bank        (abank),
    .load_done          (ldone),
    .load_error         (lerr)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts beats per packet; a packet commits only if it is exactly 256 beats.
  logic [15:0] m_mem [2][256];
  bit          m_known [2][256];
  logic [15:0] m_data [2];
  bit          m_dk [2];
  bit          m_active = 0, m_done = 0, m_err = 0, started = 0;
  int          m_cnt = 0;

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 256; i++) m_known[b][i] = 0;
    m_dk[0] = 0; m_dk[1] = 0;
  end

  always @(posedge clock) begin
    int sb, wb;
    if (!aresetn) begin
      started = 1; m_cnt = 0; m_active = 0; m_done = 0; m_err = 0;
      for (int p = 0; p < 2; p++) begin m_data[p] = 16'h0; m_dk[p] = 1; end
    end else begin
      sb = DB ? int'(m_active) : 0;
      wb = DB ? int'(!m_active) : 0;
      for (int p = 0; p < 2; p++)
        if (re[p]) begin
          m_data[p] = m_mem[sb][addr[p]];
          m_dk[p]   = m_known[sb][addr[p]];
        end
      m_done = 0; m_err = 0;
      if (tvalid) begin
        if (m_cnt < 256) begin
          m_mem[wb][m_cnt] = tdata;
          m_known[wb][m_cnt] = 1;
        end
        m_cnt++;
        if (tlast) begin
          if (m_cnt == 256) begin
            m_done = 1;
            if (DB) m_active = !m_active;
          end else m_err = 1;
          m_cnt = 0;
        end
      end
    end
  end

  int done_cnt = 0, err_cnt = 0;

  always @(negedge clock) begin
    done_cnt += int'(ldone);
    err_cnt  += int'(lerr);
    if (started) begin
      check("tready", int'(tready), int'(aresetn));
      check("active_bank", int'(abank), int'(m_active));
      check("load_done", int'(ldone), int'(m_done));
      check("load_error", int'(lerr), int'(m_err));
      for (int p = 0; p < 2; p++)
        if (m_dk[p]) check($sformatf("table_data[%0d]", p), int'(tdat[p]), int'(m_data[p]));
    end
  end

  task automatic step();
    @(negedge clock); #1;
  endtask

  function automatic logic [15:0] beat_val(input int mode, input int i);
    logic [7:0] b;
    b = 8'(i);
    case (mode)
      0:       return {b, 8'h00};
      1:       return 16'hAAAA;
      2:       return 16'h5555;
      default: return {b, ~b};
    endcase
  endfunction

  task automatic send_pkt(input int n, input int mode, input bit with_last);
    for (int i = 0; i < n; i++) begin
      tvalid = 1'b1;
      tdata  = beat_val(mode, i);
      tlast  = with_last && (i == n - 1);
      step();
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic read2(input logic [7:0] a0, input logic [7:0] a1);
    addr[0] = a0; addr[1] = a1; re = 2'b11;
    step();
    re = 2'b00;
  endtask

  initial begin
    int d0, e0;
    // Reset state
    aresetn = 1'b0;
    repeat (4) step();
    check("rst tready", int'(tready), 0);
    check("rst active_bank", int'(abank), 0);
    check("rst data0", int'(tdat[0]), 0);
    check("rst data1", int'(tdat[1]), 0);
    check("rst pulses", int'(ldone | lerr), 0);
    aresetn = 1'b1;
    step();

    // Good load of i<<8
    d0 = done_cnt;
    send_pkt(256, 0, 1);
    step();
    check("good done count", done_cnt - d0, 1);
    check("good active_bank", int'(abank), DB ? 1 : 0);
    read2(8'h10, 8'hFF);
    check("good read 0x10", int'(tdat[0]), 16'h1000);
    check("good read 0xFF", int'(tdat[1]), 16'hFF00);

    // Atomic swap while port 0 reads address 5 every cycle
    addr[0] = 8'h05; re = 2'b01;
    step();
    send_pkt(256, 1, 1);
    check("swap read at commit edge", int'(tdat[0]), DB ? 16'h0500 : 16'hAAAA);
    step();
    check("swap read after commit", int'(tdat[0]), 16'hAAAA);
    re = 2'b00;
    check("swap active_bank", int'(abank), 0);

    // Short packet (100 beats)
    d0 = done_cnt; e0 = err_cnt;
    send_pkt(100, 2, 1);
    step();
    check("short err count", err_cnt - e0, 1);
    check("short done count", done_cnt - d0, 0);
    check("short active_bank", int'(abank), 0);
    read2(8'h05, 8'hC8);
    check("short read 5", int'(tdat[0]), DB ? 16'hAAAA : 16'h5555);
    check("short read 0xC8", int'(tdat[1]), 16'hAAAA);

    // Long packet (300 beats) then an immediate good packet
    d0 = done_cnt; e0 = err_cnt;
    send_pkt(300, 0, 1);
    check("long err count", err_cnt - e0, 1);
    check("long done count", done_cnt - d0, 0);
    check("long active_bank", int'(abank), 0);
    send_pkt(256, 3, 1);
    step();
    check("after long done count", done_cnt - d0, 1);
    check("after long active_bank", int'(abank), DB ? 1 : 0);
    read2(8'h10, 8'h00);
    check("after long read 0x10", int'(tdat[0]), 16'h10EF);
    check("after long read 0x00", int'(tdat[1]), 16'h00FF);

    // Reset in the middle of a load
    d0 = done_cnt; e0 = err_cnt;
    send_pkt(129, 0, 0);
    aresetn = 1'b0;
    repeat (2) step();
    aresetn = 1'b1;
    step();
    check("midrst pulses", (done_cnt - d0) + (err_cnt - e0), 0);
    check("midrst active_bank", int'(abank), 0);
    send_pkt(256, 0, 1);
    step();
    check("midrst reload done", done_cnt - d0, 1);
    check("midrst reload active_bank", int'(abank), DB ? 1 : 0);
    read2(8'hFF, 8'h80);
    check("midrst read 0xFF", int'(tdat[0]), 16'hFF00);
    check("midrst read 0x80", int'(tdat[1]), 16'h8000);

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
